// File: rtl/r4u4_one_buf_ctrl_pkg.sv
// r4u4_one_buf_ctrl_pkg: shared widths, length encodings and FSM state types
// for the unit-4 stage-one ping-pong buffer controller.
package r4u4_one_buf_ctrl_pkg;
    localparam int MAN_WIDTH = 16;
    localparam int EXP_WIDTH = 5;
    localparam int W = 2 * MAN_WIDTH + EXP_WIDTH;
    localparam int BANK_AW = 9;
    localparam int RAM_AW = BANK_AW + 1;

    typedef enum logic [1:0] {LEN_16, LEN_64, LEN_256, LEN_256_ALT} len_sel_e;
    typedef enum logic {WR_IDLE, WR_FILL} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RUN} rd_state_e;

    // log2(N/4): quarter-frame stride used by the quartet address generator
    function automatic logic [2:0] len_shift(input logic [1:0] sel);
        return sel == LEN_16 ? 3'd2 : sel == LEN_64 ? 3'd4 :
               (sel == LEN_256 || sel == LEN_256_ALT) ? 3'd6 : 3'd6;
    endfunction
endpackage

// File: rtl/r4u4_one_buf_ctrl_if.sv
// r4u4_one_buf_ctrl_if: sample stream, stage-one RAM ports and butterfly operand bus;
// slave is the controller view, master the surrounding datapath view.
interface r4u4_one_buf_ctrl_if;
    import r4u4_one_buf_ctrl_pkg::*;
    logic [1:0] len_sel;
    logic in_valid;
    logic in_sof;
    logic [W-1:0] in_data;
    logic in_ready;
    logic ram_wr_en;
    logic [RAM_AW-1:0] ram_wr_addr;
    logic [W-1:0] ram_wr_data;
    logic [RAM_AW-1:0] ram_rd_addr;
    logic [W-1:0] ram_rd_data;
    logic out_valid;
    logic [W-1:0] out_data;
    logic [1:0] out_qidx;
    logic out_sof;
    logic out_eof;

    modport slave (
        input len_sel, in_valid, in_sof, in_data, ram_rd_data,
        output in_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
        output out_valid, out_data, out_qidx, out_sof, out_eof
    );
    modport master (
        output len_sel, in_valid, in_sof, in_data, ram_rd_data,
        input in_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr,
        input out_valid, out_data, out_qidx, out_sof, out_eof
    );
endinterface

// File: rtl/r4u4_one_rd_agen.sv
// r4u4_one_rd_agen: radix-4 stage-one read address generator; q is the inner
// quartet position, m the outer butterfly index, address = m + q*N/4.
module r4u4_one_rd_agen
    import r4u4_one_buf_ctrl_pkg::*;
(
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic en,
    input  logic [2:0] shift,
    output logic [BANK_AW-1:0] idx,
    output logic [1:0] q,
    output logic first,
    output logic last
);
    logic [BANK_AW-1:0] m;

    assign idx = m + (BANK_AW'(q) << shift);
    assign first = m == '0 && q == 2'd0;
    assign last = q == 2'd3 && m == (BANK_AW'(1) << shift) - BANK_AW'(1);

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            m <= '0;
            q <= 2'd0;
        end else if (en) begin
            q <= q + 2'd1;
            m <= last ? '0 : q == 2'd3 ? m + BANK_AW'(1) : m;
        end
    end
endmodule

// File: rtl/r4u4_one_buf_ctrl.sv
// r4u4_one_buf_ctrl: ping-pong controller for the stage-one RAM; writes frames in
// natural order into one bank while the other is read back in quartet order.
module r4u4_one_buf_ctrl
    import r4u4_one_buf_ctrl_pkg::*;
(
    input  logic clk_sys,
    input  logic rst_sys_n,
    r4u4_one_buf_ctrl_if.slave bus
);
    wr_state_e wr_st, wr_nxt;
    rd_state_e rd_st, rd_nxt;
    logic wbank, wbank_nxt, rbank, rbank_nxt;
    logic [1:0] full, full_nxt;
    logic [1:0] len_reg [2];
    logic [BANK_AW-1:0] wr_idx, wr_idx_nxt, widx, wlast, ridx;
    logic accept, wr_do, wr_done, issue, rd_first, rd_last;
    logic [1:0] rq;

    assign bus.in_ready = !full[wbank];
    assign accept = bus.in_valid && bus.in_ready;
    // a stray sample outside a frame is accepted but never written
    assign wr_do = accept && (bus.in_sof || wr_st == WR_FILL);
    assign widx = bus.in_sof ? '0 : wr_idx;
    assign wlast = (BANK_AW'(4) << len_shift(bus.in_sof ? bus.len_sel : len_reg[wbank])) - BANK_AW'(1);
    assign wr_done = wr_do && widx == wlast;
    assign bus.ram_wr_en = !wr_do;
    assign bus.ram_wr_addr = {wbank, widx};
    assign bus.ram_wr_data = bus.in_data;

    always_comb begin
        wr_nxt = wr_st;
        wr_idx_nxt = wr_idx;
        wbank_nxt = wbank;
        if (wr_do) begin
            wr_nxt = wr_done ? WR_IDLE : WR_FILL;
            wr_idx_nxt = wr_done ? '0 : widx + BANK_AW'(1);
            wbank_nxt = wbank ^ wr_done;
        end
    end

    assign issue = rd_st == RD_RUN || full[rbank];

    r4u4_one_rd_agen u_agen (
        .clk_sys(clk_sys),
        .rst_sys_n(rst_sys_n),
        .en(issue),
        .shift(len_shift(len_reg[rbank])),
        .idx(ridx),
        .q(rq),
        .first(rd_first),
        .last(rd_last)
    );

    assign bus.ram_rd_addr = {rbank, ridx};
    assign bus.out_data = bus.ram_rd_data;

    // writer and reader always own different banks, so both flag updates can land together
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wbank] = 1'b1;
        if (issue && rd_last) full_nxt[rbank] = 1'b0;
        rbank_nxt = rbank ^ (issue && rd_last);
        rd_nxt = !issue ? RD_IDLE : (rd_last && !full_nxt[!rbank]) ? RD_IDLE : RD_RUN;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            wr_st <= WR_IDLE;
            rd_st <= RD_IDLE;
            wr_idx <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full <= 2'b00;
            len_reg <= '{default: 2'd0};
            bus.out_valid <= 1'b0;
            bus.out_qidx <= 2'd0;
            bus.out_sof <= 1'b0;
            bus.out_eof <= 1'b0;
        end else begin
            wr_st <= wr_nxt;
            rd_st <= rd_nxt;
            wr_idx <= wr_idx_nxt;
            wbank <= wbank_nxt;
            rbank <= rbank_nxt;
            full <= full_nxt;
            if (accept && bus.in_sof) len_reg[wbank] <= bus.len_sel;
            bus.out_valid <= issue;
            bus.out_qidx <= rq;
            bus.out_sof <= issue && rd_first;
            bus.out_eof <= issue && rd_last;
        end
    end
endmodule

// File: tb/tb_r4u4_one_buf_ctrl.sv
// tb_r4u4_one_buf_ctrl: random and directed frames against a frame-level quartet-order
// reference model, with a behavioural registered RAM attached to the RAM ports.
module tb_r4u4_one_buf_ctrl;
    import r4u4_one_buf_ctrl_pkg::*;
    typedef logic [W+3:0] op_t;

    logic clk_sys = 1'b0;
    logic rst_sys_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    r4u4_one_buf_ctrl_if bus();
    r4u4_one_buf_ctrl dut (.clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(bus));

    logic [W-1:0] mem [1024];
    always @(posedge clk_sys) begin
        if (!bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end

    int errors = 0, checks = 0;
    op_t exp_q[$];
    logic [W-1:0] cur[$], cap[$], ref_cap[$];
    logic [W-1:0] pat [256];
    logic m_active = 1'b0, m_wbank = 1'b0;
    logic [1:0] m_len = 2'd0;
    int n4, out_cnt = 0, streak = 0, max_streak = 0;
    int acc_cnt = 0, stall_cnt = 0, drop_at = -1, rises = 0;
    logic prev_ready = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nlen(input logic [1:0] ls);
        return ls == 2'd0 ? 16 : ls == 2'd1 ? 64 : 256;
    endfunction

    // reference: collect accepted frames, emit x[m + q*N/4] for m outer, q inner
    always @(negedge clk_sys) begin
        if (bus.out_valid) begin
            out_cnt++;
            streak++;
            if (streak > max_streak) max_streak = streak;
            cap.push_back(bus.out_data);
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else chk("operand", {bus.out_data, bus.out_qidx, bus.out_sof, bus.out_eof}, exp_q.pop_front());
        end else streak = 0;
        if (!rst_sys_n) begin
            exp_q.delete();
            cur.delete();
            m_active = 1'b0;
            m_wbank = 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
            if (bus.in_sof) begin
                m_active = 1'b1;
                m_len = bus.len_sel;
                cur.delete();
            end
            if (m_active) begin
                chk("write", {bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data},
                    {1'b0, m_wbank, 9'(cur.size()), bus.in_data});
                cur.push_back(bus.in_data);
                if (cur.size() == nlen(m_len)) begin
                    n4 = nlen(m_len) / 4;
                    for (int m = 0; m < n4; m++)
                        for (int q = 0; q < 4; q++)
                            exp_q.push_back({cur[m + q * n4], 2'(q), m == 0 && q == 0, m == n4 - 1 && q == 3});
                    m_wbank = !m_wbank;
                    m_active = 1'b0;
                end
            end else chk("stray_no_write", bus.ram_wr_en, 1);
        end
    end

    task automatic send(input logic sof, input logic [1:0] ls, input logic [W-1:0] d);
        int waitc = 0;
        bus.in_valid = 1'b1;
        bus.in_sof = sof;
        bus.len_sel = ls;
        bus.in_data = d;
        forever begin
            @(negedge clk_sys);
            if (prev_ready && !bus.in_ready && drop_at < 0) drop_at = acc_cnt;
            if (!prev_ready && bus.in_ready) begin
                rises++;
                chk("ready_with_eof", bus.out_eof, 1);
            end
            prev_ready = bus.in_ready;
            if (bus.in_ready) begin
                acc_cnt++;
                break;
            end
            stall_cnt++;
            if (++waitc > 2000) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk_sys);
            #1;
        end
        @(posedge clk_sys);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // mode 0: ramp data, 1: random data, 2: stored pattern
    task automatic frame(input logic [1:0] ls, input int n, input int mode, input int gap_max);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
            send(i == 0, ls, mode == 0 ? W'(i) : mode == 1 ? W'({$urandom, $urandom}) : pat[i]);
        end
    endtask

    task automatic drain();
        int c = 0;
        while ((exp_q.size() > 0 || bus.out_valid) && c < 3000) begin
            @(negedge clk_sys);
            c++;
        end
        repeat (3) @(negedge clk_sys);
        chk("drain_empty", 64'(exp_q.size()), 0);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_wr_en"}, bus.ram_wr_en, 1);
        chk({tag, "_wr_addr"}, bus.ram_wr_addr, 0);
        chk({tag, "_rd_addr"}, bus.ram_rd_addr, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_sof"}, bus.out_sof, 0);
        chk({tag, "_out_eof"}, bus.out_eof, 0);
        chk({tag, "_out_qidx"}, bus.out_qidx, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, mism, n;
        logic [1:0] ls;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.len_sel = 2'd0;
        bus.in_data = '0;
        repeat (3) @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;
        @(negedge clk_sys);
        chk_reset_outputs("rst");
        @(posedge clk_sys);
        #1;

        out_cnt = 0;
        frame(2'd0, 16, 0, 0);
        drain();
        chk("n16_count", 64'(out_cnt), 16);

        out_cnt = 0;
        stall_cnt = 0;
        max_streak = 0;
        repeat (3) frame(2'd1, 64, 1, 0);
        drain();
        chk("n64_no_stall", 64'(stall_cnt), 0);
        chk("n64_gap_free", 64'(max_streak), 192);
        chk("n64_count", 64'(out_cnt), 192);

        out_cnt = 0;
        frame(2'd2, 10, 1, 0);
        frame(2'd2, 256, 1, 0);
        drain();
        chk("restart_count", 64'(out_cnt), 256);

        acc_cnt = 0;
        drop_at = -1;
        rises = 0;
        out_cnt = 0;
        frame(2'd2, 256, 1, 0);
        repeat (3) frame(2'd0, 16, 1, 0);
        drain();
        chk("ready_drop_at", 64'(drop_at), 272);
        chk("ready_rise_seen", 64'(rises), 1);
        chk("stall_count", 64'(out_cnt), 304);

        out_cnt = 0;
        frame(2'd1, 64, 0, 0);
        c = 0;
        while (out_cnt < 37 && c < 500) begin
            @(negedge clk_sys);
            c++;
        end
        chk("reach_op37", 64'(out_cnt), 37);
        @(posedge clk_sys);
        #1 rst_sys_n = 1'b0;
        @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;
        prev_ready = 1'b1;
        @(negedge clk_sys);
        chk_reset_outputs("midrst");
        @(posedge clk_sys);
        #1;
        out_cnt = 0;
        frame(2'd0, 16, 0, 0);
        drain();
        chk("post_rst_count", 64'(out_cnt), 16);

        for (int i = 0; i < 256; i++) pat[i] = W'({$urandom, $urandom});
        cap.delete();
        frame(2'd2, 256, 2, 0);
        drain();
        ref_cap = cap;
        cap.delete();
        frame(2'd3, 256, 2, 0);
        drain();
        chk("ls3_len", 64'(cap.size()), 64'(ref_cap.size()));
        mism = 0;
        for (int i = 0; i < cap.size() && i < ref_cap.size(); i++) if (cap[i] !== ref_cap[i]) mism++;
        chk("ls3_same", 64'(mism), 0);

        for (int it = 0; it < 12; it++) begin
            ls = 2'($urandom_range(3, 0));
            n = nlen(ls);
            if ($urandom_range(3, 0) == 0) frame(ls, int'($urandom_range(n - 1, 1)), 1, 1);
            if ($urandom_range(2, 0) == 0) send(1'b0, ls, W'($urandom));
            frame(ls, n, 1, $urandom_range(1, 0) == 0 ? 0 : 2);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
